stream_seq_checker: RTL and testbench
=====================================

# stream_seq_checker

Read-domain consumer placed directly after the dual-clock continuous-output FIFO. It takes the FIFO's output word, which carries an in-band valid bit at `EN_BIT` with the payload around it. It groups valid words into frames and checks that payloads increment by one. It reports sequence errors, underrun gaps and frame/word statistics through saturating counters and one-cycle pulses.

## Interface
- `DW`, 27: total word width including the in-band valid bit.
- `EN_BIT`, 25: position of the valid bit; payload is `{din[DW-1:EN_BIT+1], din[EN_BIT-1:0]}`, width DW-1.
- `CNT_W`, 16: width of every statistics counter.
- `GAP_TOL`, 2: longest run of invalid cycles, from 0 to 255, tolerated inside a frame.
- `CLK`  in  1: read-side clock.
- `RST_X`  in  1: asynchronous, active-low reset.
- `clr`  in  1: synchronous clear of state and counters.
- `din`  in  DW: FIFO output word; `din[EN_BIT]`=1 marks a valid word.
- `frame_start`  out  1: pulse on the first word of a frame.
- `frame_end`  out  1: pulse when a frame closes.
- `seq_err`  out  1: pulse on a payload mismatch.
- `in_frame`  out  1: high while the state is RUN or GAP.
- `word_cnt`  out  CNT_W: valid words accepted.
- `frame_cnt`  out  CNT_W: frames opened.
- `err_cnt`  out  CNT_W: sequence mismatches.
- `gap_cnt`  out  CNT_W: tolerated gaps, i.e. frames resumed from GAP.

## Operation
- State machine IDLE / RUN / GAP; `exp` is a register of width DW-1; `gcnt` is an 8-bit run counter.
- IDLE, valid word:
  - go to RUN, pulse `frame_start`;
  - `frame_cnt`++ and `word_cnt`++;
  - `exp` = payload+1; the first word of a frame is never checked.
- IDLE, invalid cycle: stay in IDLE.
- RUN, valid word: check it (see below) and stay in RUN.
- RUN, invalid cycle:
  - if GAP_TOL=0, go to IDLE and pulse `frame_end`;
  - otherwise go to GAP with `gcnt`=1.
- GAP, valid word: go to RUN, `gap_cnt`++, check the word.
- GAP, invalid cycle:
  - if `gcnt`==GAP_TOL, go to IDLE and pulse `frame_end`;
  - otherwise `gcnt`++.
- Check:
  - `word_cnt`++;
  - if payload≠`exp`, pulse `seq_err` and `err_cnt`++;
  - in all cases `exp` = payload+1, which resyncs after an error.
- Arithmetic: `exp` wraps modulo 2^(DW-1), so all-ones followed by zero is not an error. All counters saturate at 2^CNT_W−1 and never wrap.
- `clr`:
  - has priority over everything;
  - sets state to IDLE and zeroes all counters and `exp`;
  - suppresses pulses in the same cycle;
  - a word presented with `clr` is dropped from the statistics.

## Timing
- All outputs are registered. An effect of `din` sampled at edge N is visible after edge N; pulses are exactly one cycle wide.
- Reset: state IDLE; every output, `exp` and `gcnt` are 0.
- Reset asserted mid-frame: immediate return to the reset values. The next valid word after release opens a new frame.
- No backpressure; a valid word is consumed every cycle it is present.

## Configuration
- `SEQCHK_CAPTURE_EN` defined adds outputs `err_exp` and `err_got` (each DW-1 wide) and `err_hold` (1 bit).
  - They latch the expected and received payloads of the first mismatch after reset or `clr`.
  - `err_hold` is set by that first mismatch; later errors do not overwrite the latched values.
  - All three return to 0 on reset or `clr`.
- Macro undefined: these ports and their registers are absent.

## Structure
- Shared package `stream_pkg` holds:
  - the state typedef (IDLE/RUN/GAP);
  - default DW/EN_BIT constants;
  - payload width `DW-1`.
- One sub-module, `sat_counter` (CNT_W, synchronous clear, increment enable, saturation), instantiated four times.

## Test plan
- 100 consecutive valid words, payload 0..99, GAP_TOL=2 -> `frame_cnt`=1, `word_cnt`=100, `err_cnt`=0, one `frame_start`, one `frame_end` 3 cycles after the last word.
- Payload 0..9, then a 2-cycle invalid gap, then 10..19 -> `frame_cnt`=1, `gap_cnt`=1, `err_cnt`=0.
- Same stream with a 3-cycle gap -> `frame_cnt`=2, `gap_cnt`=0, `frame_end` pulses twice.
- Payload sequence 5,6,8,9 -> one `seq_err` on the word 8, `err_cnt`=1, no error on 9. With `SEQCHK_CAPTURE_EN`: `err_exp`=7, `err_got`=8.
- Payload 2^26−2, 2^26−1, 0, 1 -> `err_cnt`=0. With CNT_W=4, 20 frames -> `frame_cnt`=15.
- `clr` and a valid word in the same cycle mid-frame, then `RST_X` low for 1 cycle -> counters 0 and state IDLE after each; no pulse in either cycle.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: shared state encoding and default word geometry for the stream checker slice.
package stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
    localparam int DW_DEF     = 27;
    localparam int EN_BIT_DEF = 25;
    localparam int PW_DEF     = DW_DEF - 1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_X,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge CLK or negedge RST_X)
        if (!RST_X) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/stream_seq_checker.sv
// stream_seq_checker: frames valid FIFO words, checks +1 payload sequence, keeps saturating stats.
// Define SEQCHK_CAPTURE_EN to add err_exp/err_got/err_hold first-mismatch capture.
module stream_seq_checker
    import stream_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int EN_BIT  = EN_BIT_DEF,
    parameter int CNT_W   = 16,
    parameter int GAP_TOL = 2
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             clr,
    input  logic [DW-1:0]    din,
    output logic             frame_start,
    output logic             frame_end,
    output logic             seq_err,
    output logic             in_frame,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] gap_cnt
`ifdef SEQCHK_CAPTURE_EN
    ,
    output logic [DW-2:0]    err_exp,
    output logic [DW-2:0]    err_got,
    output logic             err_hold
`endif
);
    localparam int PW = DW - 1;

    state_t        state, state_n;
    logic [PW-1:0] exp, exp_n, payload;
    logic [7:0]    gcnt, gcnt_n;
    logic          valid, fs_n, fe_n, chk, gap_inc, mismatch;

    assign valid    = din[EN_BIT];
    assign payload  = {din[DW-1:EN_BIT+1], din[EN_BIT-1:0]};
    assign in_frame = state != IDLE;
    assign mismatch = chk && payload != exp;

    always_comb begin
        state_n = state;
        gcnt_n  = gcnt;
        exp_n   = exp;
        fs_n    = 1'b0;
        fe_n    = 1'b0;
        chk     = 1'b0;
        gap_inc = 1'b0;
        case (state)
            IDLE: if (valid) begin
                state_n = RUN;
                fs_n    = 1'b1;
                exp_n   = payload + PW'(1);
            end
            RUN: if (valid) chk = 1'b1;
            else if (GAP_TOL == 0) begin
                state_n = IDLE;
                fe_n    = 1'b1;
            end else begin
                state_n = GAP;
                gcnt_n  = 8'd1;
            end
            GAP: if (valid) begin
                state_n = RUN;
                gap_inc = 1'b1;
                chk     = 1'b1;
            end else if (gcnt == 8'(GAP_TOL)) begin
                state_n = IDLE;
                fe_n    = 1'b1;
            end else gcnt_n = gcnt + 8'd1;
            default: state_n = IDLE;
        endcase
        // every checked word resyncs the expectation, so one bad word costs one error
        if (chk) exp_n = payload + PW'(1);
    end

    always_ff @(posedge CLK or negedge RST_X)
        if (!RST_X || clr) begin
            state       <= IDLE;
            exp         <= '0;
            gcnt        <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_n;
            exp         <= exp_n;
            gcnt        <= gcnt_n;
            frame_start <= fs_n;
            frame_end   <= fe_n;
            seq_err     <= mismatch;
        end

    sat_counter #(.W(CNT_W)) u_word  (.CLK(CLK), .RST_X(RST_X), .clr(clr), .inc(fs_n | chk), .cnt(word_cnt));
    sat_counter #(.W(CNT_W)) u_frame (.CLK(CLK), .RST_X(RST_X), .clr(clr), .inc(fs_n),       .cnt(frame_cnt));
    sat_counter #(.W(CNT_W)) u_err   (.CLK(CLK), .RST_X(RST_X), .clr(clr), .inc(mismatch),   .cnt(err_cnt));
    sat_counter #(.W(CNT_W)) u_gap   (.CLK(CLK), .RST_X(RST_X), .clr(clr), .inc(gap_inc),    .cnt(gap_cnt));

`ifdef SEQCHK_CAPTURE_EN
    always_ff @(posedge CLK or negedge RST_X)
        if (!RST_X || clr) begin
            err_exp  <= '0;
            err_got  <= '0;
            err_hold <= 1'b0;
        end else if (mismatch && !err_hold) begin
            err_exp  <= exp;
            err_got  <= payload;
            err_hold <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_stream_seq_checker.sv
// tb_stream_seq_checker: directed scenarios with hand-computed expectations for stream_seq_checker.
module tb_stream_seq_checker;
    logic        CLK = 1'b0;
    logic        RST_X, clr;
    logic [26:0] din;
    logic        frame_start, frame_end, seq_err, in_frame;
    logic [15:0] word_cnt, frame_cnt, err_cnt, gap_cnt;
    logic        fs4, fe4, se4, if4;
    logic [3:0]  word_cnt4, frame_cnt4, err_cnt4, gap_cnt4;
`ifdef SEQCHK_CAPTURE_EN
    logic [25:0] err_exp, err_got, err_exp4, err_got4;
    logic        err_hold, err_hold4;
`endif
    int errors = 0, checks = 0;
    int fs_seen, fe_seen, se_seen;

    always #5 CLK = ~CLK;

    stream_seq_checker dut (
        .CLK(CLK), .RST_X(RST_X), .clr(clr), .din(din),
        .frame_start(frame_start), .frame_end(frame_end), .seq_err(seq_err), .in_frame(in_frame),
        .word_cnt(word_cnt), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .gap_cnt(gap_cnt)
`ifdef SEQCHK_CAPTURE_EN
        , .err_exp(err_exp), .err_got(err_got), .err_hold(err_hold)
`endif
    );

    stream_seq_checker #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST_X(RST_X), .clr(clr), .din(din),
        .frame_start(fs4), .frame_end(fe4), .seq_err(se4), .in_frame(if4),
        .word_cnt(word_cnt4), .frame_cnt(frame_cnt4), .err_cnt(err_cnt4), .gap_cnt(gap_cnt4)
`ifdef SEQCHK_CAPTURE_EN
        , .err_exp(err_exp4), .err_got(err_got4), .err_hold(err_hold4)
`endif
    );

    task automatic step(input logic v, input logic [25:0] p);
        din = {p[25], v, p[24:0]};
        @(posedge CLK);
        #1;
        fs_seen += int'(frame_start);
        fe_seen += int'(frame_end);
        se_seen += int'(seq_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 26'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1'b0, 26'd0);
        clr = 1'b0;
        fs_seen = 0;
        fe_seen = 0;
        se_seen = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (word_cnt !== 16'd0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0 || gap_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnts got=%0d/%0d/%0d/%0d exp=0", word_cnt, frame_cnt, err_cnt, gap_cnt); end
        checks++; if ({frame_start, frame_end, seq_err, in_frame} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {frame_start, frame_end, seq_err, in_frame}); end
`ifdef SEQCHK_CAPTURE_EN
        checks++; if ({err_exp, err_got, err_hold} !== 53'd0) begin errors++; $display("FAIL reset_capture got=%0h exp=0", {err_exp, err_got, err_hold}); end
`endif
        @(posedge CLK);
        #1;
        RST_X = 1'b1;
    endtask

    task automatic test_long_frame();
        do_clr();
        for (int i = 0; i < 100; i++) step(1'b1, 26'(i));
        checks++; if (in_frame !== 1'b1) begin errors++; $display("FAIL long_in_frame got=%b exp=1", in_frame); end
        idle(2);
        checks++; if (frame_end !== 1'b0 || in_frame !== 1'b1) begin errors++; $display("FAIL long_early_end got fe=%b in=%b exp fe=0 in=1", frame_end, in_frame); end
        idle(1);
        checks++; if (frame_end !== 1'b1 || in_frame !== 1'b0) begin errors++; $display("FAIL long_end got fe=%b in=%b exp fe=1 in=0", frame_end, in_frame); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL long_frame_cnt got=%0d exp=1", frame_cnt); end
        checks++; if (word_cnt !== 16'd100) begin errors++; $display("FAIL long_word_cnt got=%0d exp=100", word_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL long_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (fs_seen != 1 || fe_seen != 1) begin errors++; $display("FAIL long_pulses got fs=%0d fe=%0d exp 1/1", fs_seen, fe_seen); end
    endtask

    task automatic test_gap(input int g, input int exp_frames, input int exp_gaps);
        do_clr();
        for (int i = 0; i < 10; i++) step(1'b1, 26'(i));
        idle(g);
        for (int i = 10; i < 20; i++) step(1'b1, 26'(i));
        idle(3);
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL gap%0d_frame_cnt got=%0d exp=%0d", g, frame_cnt, exp_frames); end
        checks++; if (gap_cnt !== 16'(exp_gaps)) begin errors++; $display("FAIL gap%0d_gap_cnt got=%0d exp=%0d", g, gap_cnt, exp_gaps); end
        checks++; if (err_cnt !== 16'd0 || word_cnt !== 16'd20) begin errors++; $display("FAIL gap%0d_words got err=%0d words=%0d exp 0/20", g, err_cnt, word_cnt); end
        checks++; if (fe_seen != exp_frames || fs_seen != exp_frames) begin errors++; $display("FAIL gap%0d_pulses got fs=%0d fe=%0d exp %0d", g, fs_seen, fe_seen, exp_frames); end
    endtask

    task automatic test_seq_err();
        do_clr();
        step(1'b1, 26'd5);
        step(1'b1, 26'd6);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL err_on6 got=%b exp=0", seq_err); end
        step(1'b1, 26'd8);
        checks++; if (seq_err !== 1'b1 || err_cnt !== 16'd1) begin errors++; $display("FAIL err_on8 got se=%b cnt=%0d exp 1/1", seq_err, err_cnt); end
        step(1'b1, 26'd9);
        checks++; if (seq_err !== 1'b0 || err_cnt !== 16'd1) begin errors++; $display("FAIL err_on9 got se=%b cnt=%0d exp 0/1", seq_err, err_cnt); end
`ifdef SEQCHK_CAPTURE_EN
        checks++; if (err_exp !== 26'd7 || err_got !== 26'd8 || err_hold !== 1'b1) begin errors++; $display("FAIL capture got exp=%0d got=%0d hold=%b exp 7/8/1", err_exp, err_got, err_hold); end
`endif
        step(1'b1, 26'd20);
        checks++; if (err_cnt !== 16'd2 || se_seen != 2) begin errors++; $display("FAIL err_second got cnt=%0d pulses=%0d exp 2/2", err_cnt, se_seen); end
`ifdef SEQCHK_CAPTURE_EN
        checks++; if (err_exp !== 26'd7 || err_got !== 26'd8) begin errors++; $display("FAIL capture_hold got exp=%0d got=%0d exp 7/8", err_exp, err_got); end
`endif
        idle(3);
    endtask

    task automatic test_wrap();
        do_clr();
        step(1'b1, 26'h3FF_FFFE);
        step(1'b1, 26'h3FF_FFFF);
        step(1'b1, 26'd0);
        step(1'b1, 26'd1);
        checks++; if (err_cnt !== 16'd0 || word_cnt !== 16'd4 || se_seen != 0) begin errors++; $display("FAIL wrap got err=%0d words=%0d pulses=%0d exp 0/4/0", err_cnt, word_cnt, se_seen); end
        idle(3);
    endtask

    task automatic test_saturate();
        do_clr();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 26'(i));
            idle(3);
        end
        checks++; if (frame_cnt4 !== 4'd15 || word_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got frames=%0d words=%0d exp 15/15", frame_cnt4, word_cnt4); end
        checks++; if (frame_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got=%0d exp=20", frame_cnt); end
    endtask

    task automatic test_clr_reset_mid();
        do_clr();
        step(1'b1, 26'd0);
        step(1'b1, 26'd1);
        step(1'b1, 26'd2);
        clr = 1'b1;
        step(1'b1, 26'd3);
        clr = 1'b0;
        checks++; if (word_cnt !== 16'd0 || frame_cnt !== 16'd0 || in_frame !== 1'b0) begin errors++; $display("FAIL clr_state got words=%0d frames=%0d in=%b exp 0/0/0", word_cnt, frame_cnt, in_frame); end
        checks++; if ({frame_start, frame_end, seq_err} !== 3'b0) begin errors++; $display("FAIL clr_pulses got=%b exp=000", {frame_start, frame_end, seq_err}); end
        step(1'b1, 26'd4);
        checks++; if (frame_start !== 1'b1 || word_cnt !== 16'd1 || frame_cnt !== 16'd1) begin errors++; $display("FAIL clr_reopen got fs=%b words=%0d frames=%0d exp 1/1/1", frame_start, word_cnt, frame_cnt); end
        step(1'b1, 26'd5);
        din = {1'b0, 1'b1, 25'd6};
        RST_X = 1'b0;
        #1;
        checks++; if (word_cnt !== 16'd0 || frame_cnt !== 16'd0 || in_frame !== 1'b0) begin errors++; $display("FAIL rst_async got words=%0d frames=%0d in=%b exp 0/0/0", word_cnt, frame_cnt, in_frame); end
        @(posedge CLK);
        #1;
        checks++; if ({frame_start, frame_end, seq_err, in_frame} !== 4'b0 || word_cnt !== 16'd0) begin errors++; $display("FAIL rst_hold got flags=%b words=%0d exp 0000/0", {frame_start, frame_end, seq_err, in_frame}, word_cnt); end
        RST_X = 1'b1;
        step(1'b1, 26'd7);
        checks++; if (frame_start !== 1'b1 || frame_cnt !== 16'd1 || in_frame !== 1'b1) begin errors++; $display("FAIL rst_reopen got fs=%b frames=%0d in=%b exp 1/1/1", frame_start, frame_cnt, in_frame); end
        idle(3);
    endtask

    initial begin
        RST_X = 1'b0;
        clr = 1'b0;
        din = '0;
        fs_seen = 0;
        fe_seen = 0;
        se_seen = 0;
        test_reset();
        test_long_frame();
        test_gap(2, 1, 1);
        test_gap(3, 2, 0);
        test_seq_err();
        test_wrap();
        test_saturate();
        test_clr_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
